pulse_stretcher: RTL

Converts single-cycle event pulses (hop, collision, score events) into fixed-length output levels for LEDs, sound enables and display flashes. It is the counterpart of the press-to-single-pulse conditioner: that block turns held levels into one-cycle pulses, and this block turns one-cycle pulses back into held levels. Requests that arrive during an active stretch are queued in a saturating pending counter. Consecutive stretches are separated by a guaranteed low gap, so a downstream edge detector sees each one as a distinct event.

---
 rtl/pulse_stretch_pkg.sv | 12 +
 rtl/rise_detect.sv | 22 ++
 rtl/pulse_stretcher.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and sizing helper for the pulse stretcher.
// Used by pulse_stretcher; the edge option is selected there with PULSE_STRETCH_EDGE_EN.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} ps_state_t;

  // Bits needed to hold the values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge detector against a registered previous sample.
// The previous sample resets to 0, so an input already high out of reset counts as a rise.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle request pulses into HOLD_CYCLES-long levels, queueing overlaps.
// Define PULSE_STRETCH_EDGE_EN to accept only 0->1 transitions of pulse_in as requests.
module pulse_stretcher
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 1,
  parameter int PEND_MAX    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pulse_in,
  output logic                           level_out,
  output logic                           busy,
  output logic [cnt_width(PEND_MAX)-1:0] pending,
  output logic                           overflow
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int PEND_W  = cnt_width(PEND_MAX);

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

  ps_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              level_q, level_d;
  logic              req;
  logic              gap_done;

`ifdef PULSE_STRETCH_EDGE_EN
  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .in    (pulse_in),
    .rise  (req)
  );
`else
  assign req = pulse_in;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ovf_d    = 1'b0;
    gap_done = (state_q == GAP) && (cnt_q == '0);

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          // A request on this final cycle already counts toward the GAP decision.
          if ((GAP_CYCLES > 0) && ((pend_q != '0) || req)) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Request coinciding with the GAP->HOLD dequeue cancels out, even when full.
    if (state_q != IDLE) begin
      if (req && !gap_done) begin
        if (pend_q == PEND_FULL) ovf_d  = 1'b1;
        else                     pend_d = pend_q + 1'b1;
      end else if (!req && gap_done) begin
        pend_d = pend_q - 1'b1;
      end
    end

    level_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
    end
  end

  assign level_out = level_q;
  assign busy      = (state_q != IDLE);
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule
